// File: rtl/perceptron_cmd_responder.sv
// perceptron_cmd_responder
//   Byte-oriented command front end for a two-input perceptron. It decodes
//   opcodes arriving from a UART receiver. READ returns the stored weights and
//   the perceptron result. WRITE_WEIGHTS and WRITE_INPUTS each load a register
//   pair from a 4-byte payload. Every response is sent one byte at a time using
//   the tx_start/tx_busy handshake.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   rx_valid/rx_data/rx_error received byte strobe, byte, framing error
//   tx_start/tx_data/tx_busy  transmit request, byte, transmitter busy
//   weight1/2, input1/2       stored words
//   result                    perceptron output (already stepped)
//   weights_we, inputs_we     one-cycle pulse when a pair is updated
//   cont_state                current FSM state code
module perceptron_cmd_responder #(
  parameter int unsigned DATA_WIDTH     = 16,
  parameter int unsigned TIMEOUT_CYCLES = 120000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx_valid,
  input  logic [7:0]            rx_data,
  input  logic                  rx_error,
  output logic                  tx_start,
  output logic [7:0]            tx_data,
  input  logic                  tx_busy,
  output logic [DATA_WIDTH-1:0] weight1,
  output logic [DATA_WIDTH-1:0] weight2,
  output logic [DATA_WIDTH-1:0] input1,
  output logic [DATA_WIDTH-1:0] input2,
  input  logic [DATA_WIDTH-1:0] result,
  output logic                  weights_we,
  output logic                  inputs_we,
  output logic [4:0]            cont_state
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [7:0] OP_READ     = 8'd5;
  localparam logic [7:0] OP_WR_W     = 8'd50;
  localparam logic [7:0] OP_WR_I     = 8'd51;
  localparam logic [7:0] RSP_READ    = 8'd100;
  localparam logic [7:0] RSP_OK      = 8'd101;
  localparam logic [7:0] RSP_ERR     = 8'd102;

  typedef enum logic [4:0] {
    S_IDLE         = 5'd0,
    S_RX_PAYLOAD   = 5'd1,
    S_COMMIT       = 5'd2,
    S_TX_LOAD      = 5'd3,
    S_TX_WAIT_BUSY = 5'd4,
    S_TX_WAIT_DONE = 5'd5,
    S_ERROR        = 5'd6
  } state_t;

  state_t                state_q, state_d;
  logic [1:0]            byte_cnt_q, byte_cnt_d;
  logic [31:0]           pay_q, pay_d;
  logic                  target_q, target_d;   // 1: inputs pair, 0: weights pair
  logic [TW-1:0]         timer_q, timer_d;
  logic [7:0]            resp_q [8];
  logic [7:0]            resp_d [8];
  logic [2:0]            len_q, len_d;
  logic [2:0]            idx_q, idx_d;
  logic [DATA_WIDTH-1:0] w1_q, w1_d, w2_q, w2_d, i1_q, i1_d, i2_q, i2_d;
  logic                  weights_we_q, weights_we_d;
  logic                  inputs_we_q, inputs_we_d;

  logic [15:0] w1_16, w2_16, res_16;

  assign w1_16  = 16'(w1_q);
  assign w2_16  = 16'(w2_q);
  assign res_16 = 16'(result);

  always_comb begin
    state_d      = state_q;
    byte_cnt_d   = byte_cnt_q;
    pay_d        = pay_q;
    target_d     = target_q;
    timer_d      = timer_q;
    resp_d       = resp_q;
    len_d        = len_q;
    idx_d        = idx_q;
    w1_d         = w1_q;
    w2_d         = w2_q;
    i1_d         = i1_q;
    i2_d         = i2_q;
    weights_we_d = 1'b0;
    inputs_we_d  = 1'b0;
    tx_start     = 1'b0;
    tx_data      = '0;

    case (state_q)
      S_IDLE: begin
        if (rx_error) begin
          state_d = S_ERROR;
        end else if (rx_valid) begin
          idx_d = '0;
          case (rx_data)
            OP_READ: begin
              // The snapshot is taken here, so later result changes do not reach bytes already queued.
              resp_d[0] = RSP_READ;
              resp_d[1] = w1_16[15:8];
              resp_d[2] = w1_16[7:0];
              resp_d[3] = w2_16[15:8];
              resp_d[4] = w2_16[7:0];
              resp_d[5] = res_16[15:8];
              resp_d[6] = res_16[7:0];
              len_d     = 3'd7;
              state_d   = S_TX_LOAD;
            end
            OP_WR_W, OP_WR_I: begin
              target_d   = (rx_data == OP_WR_I);
              byte_cnt_d = '0;
              timer_d    = '0;
              state_d    = S_RX_PAYLOAD;
            end
            default: begin
              resp_d[0] = RSP_ERR;
              len_d     = 3'd1;
              state_d   = S_TX_LOAD;
            end
          endcase
        end
      end

      S_RX_PAYLOAD: begin
        if (rx_error) begin
          state_d = S_ERROR;
        end else if (rx_valid) begin
          pay_d      = {pay_q[23:0], rx_data};
          timer_d    = '0;
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) state_d = S_COMMIT;
        end else if (timer_q == TW'(TIMEOUT_CYCLES - 1)) begin
          state_d = S_ERROR;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end

      S_COMMIT: begin
        if (rx_error) begin
          state_d = S_ERROR;
        end else begin
          if (target_q) begin
            i1_d        = DATA_WIDTH'(pay_q[31:16]);
            i2_d        = DATA_WIDTH'(pay_q[15:0]);
            inputs_we_d = 1'b1;
          end else begin
            w1_d         = DATA_WIDTH'(pay_q[31:16]);
            w2_d         = DATA_WIDTH'(pay_q[15:0]);
            weights_we_d = 1'b1;
          end
          resp_d[0] = RSP_OK;
          len_d     = 3'd1;
          idx_d     = '0;
          state_d   = S_TX_LOAD;
        end
      end

      S_ERROR: begin
        resp_d[0] = RSP_ERR;
        len_d     = 3'd1;
        idx_d     = '0;
        state_d   = S_TX_LOAD;
      end

      S_TX_LOAD: begin
        tx_start = 1'b1;
        tx_data  = resp_q[idx_q];
        state_d  = S_TX_WAIT_BUSY;
      end

      S_TX_WAIT_BUSY: begin
        tx_start = 1'b1;
        tx_data  = resp_q[idx_q];
        if (tx_busy) state_d = S_TX_WAIT_DONE;
      end

      S_TX_WAIT_DONE: begin
        if (!tx_busy) begin
          if (idx_q == len_q - 3'd1) begin
            state_d = S_IDLE;
          end else begin
            idx_d   = idx_q + 3'd1;
            state_d = S_TX_LOAD;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      byte_cnt_q   <= '0;
      pay_q        <= '0;
      target_q     <= 1'b0;
      timer_q      <= '0;
      len_q        <= '0;
      idx_q        <= '0;
      w1_q         <= '0;
      w2_q         <= '0;
      i1_q         <= '0;
      i2_q         <= '0;
      weights_we_q <= 1'b0;
      inputs_we_q  <= 1'b0;
      for (int unsigned i = 0; i < 8; i++) resp_q[i] <= '0;
    end else begin
      state_q      <= state_d;
      byte_cnt_q   <= byte_cnt_d;
      pay_q        <= pay_d;
      target_q     <= target_d;
      timer_q      <= timer_d;
      len_q        <= len_d;
      idx_q        <= idx_d;
      w1_q         <= w1_d;
      w2_q         <= w2_d;
      i1_q         <= i1_d;
      i2_q         <= i2_d;
      weights_we_q <= weights_we_d;
      inputs_we_q  <= inputs_we_d;
      for (int unsigned i = 0; i < 8; i++) resp_q[i] <= resp_d[i];
    end
  end

  assign weight1    = w1_q;
  assign weight2    = w2_q;
  assign input1     = i1_q;
  assign input2     = i2_q;
  assign weights_we = weights_we_q;
  assign inputs_we  = inputs_we_q;
  assign cont_state = state_q;

endmodule
